// File: rtl/sec_stage.sv
// Seconds stage: DIV prescaler, BCD 00..59 count, run/pause/halt FSM, 7-seg out.
// Optional lap-freeze display under SEC_STAGE_LAP_EN (adds LAP input).
module sec_stage #(
  parameter int DIV = 50000000
) (
  input  logic       CLK,
  input  logic       RST_N,
`ifdef SEC_STAGE_LAP_EN
  input  logic       LAP,
`endif
  input  logic       START,
  input  logic       PAUSE,
  input  logic       CLEAR,
  input  logic       LOAD,
  input  logic [2:0] LOAD_TENS,
  input  logic [3:0] LOAD_UNITS,
  input  logic       MIN_MAX,
  output logic       CLK_OUT,
  output logic [6:0] SEG_U,
  output logic [6:0] SEG_T,
  output logic       RUNNING,
  output logic       DONE
);

  localparam int PW = (DIV > 2) ? $clog2(DIV) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_PAUSE,
    S_HALT
  } state_t;

  state_t        state;
  state_t        state_nx;
  logic [PW-1:0] pre;
  logic [2:0]    tens;
  logic [3:0]    units;
  logic          carry;
  logic [2:0]    disp_t;
  logic [3:0]    disp_u;

  logic load_ok;
  logic run_go;
  logic tick;
  logic roll;
  logic go_pause;
  logic go_run;
  logic go_halt;

  function automatic logic [6:0] seg7(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'b1111110;
      4'd1:    s = 7'b0110000;
      4'd2:    s = 7'b1101101;
      4'd3:    s = 7'b1111001;
      4'd4:    s = 7'b0110011;
      4'd5:    s = 7'b1011011;
      4'd6:    s = 7'b1011111;
      4'd7:    s = 7'b1110000;
      4'd8:    s = 7'b1111111;
      4'd9:    s = 7'b1111011;
      default: s = 7'b0000000;
    endcase
    return s;
  endfunction

  // Mutually exclusive terms encode CLEAR > LOAD > PAUSE > START > tick.
  always_comb begin
    load_ok  = LOAD & ((state == S_IDLE) | (state == S_PAUSE));
    run_go   = (state == S_RUN) & ~CLEAR & ~PAUSE;
    tick     = run_go & (pre == PW'(DIV - 1));
    roll     = tick & (tens == 3'd5) & (units == 4'd9);
    go_pause = (state == S_RUN) & PAUSE & ~CLEAR;
    go_run   = ((state == S_IDLE) | (state == S_PAUSE))
             & START & ~CLEAR & ~load_ok;
    go_halt  = roll & MIN_MAX;
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) state <= S_IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (1'b1)
      CLEAR:    state_nx = S_IDLE;
      go_pause: state_nx = S_PAUSE;
      go_run:   state_nx = S_RUN;
      go_halt:  state_nx = S_HALT;
      default:  state_nx = state;
    endcase
  end

  always_comb begin
    RUNNING = (state == S_RUN);
    DONE    = (state == S_HALT);
    CLK_OUT = carry;
  end

  // Resume from PAUSE keeps the partial period; only a fresh start zeroes it.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      pre <= '0;
    end else if (CLEAR | load_ok | (go_run & (state == S_IDLE))) begin
      pre <= '0;
    end else if (run_go) begin
      pre <= tick ? '0 : pre + PW'(1);
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      tens  <= '0;
      units <= '0;
      carry <= 1'b0;
    end else begin
      carry <= roll & ~MIN_MAX;
      if (CLEAR) begin
        tens  <= '0;
        units <= '0;
      end else if (load_ok) begin
        tens  <= (LOAD_TENS > 3'd5) ? 3'd5 : LOAD_TENS;
        units <= (LOAD_UNITS > 4'd9) ? 4'd9 : LOAD_UNITS;
      end else if (tick) begin
        if (roll) begin
          if (!MIN_MAX) begin
            tens  <= '0;
            units <= '0;
          end
        end else if (units == 4'd9) begin
          units <= '0;
          tens  <= tens + 3'd1;
        end else begin
          units <= units + 4'd1;
        end
      end
    end
  end

`ifdef SEC_STAGE_LAP_EN
  logic       lap_q;
  logic       frozen;
  logic [2:0] lap_t;
  logic [3:0] lap_u;
  logic       lap_rise;

  assign lap_rise = LAP & ~lap_q;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      lap_q  <= 1'b0;
      frozen <= 1'b0;
      lap_t  <= '0;
      lap_u  <= '0;
    end else begin
      lap_q <= LAP;
      if (CLEAR | (state_nx != S_RUN)) begin
        frozen <= 1'b0;
      end else if (lap_rise) begin
        if (frozen) begin
          frozen <= 1'b0;
        end else if (state == S_RUN) begin
          frozen <= 1'b1;
          lap_t  <= tens;
          lap_u  <= units;
        end
      end
    end
  end

  always_comb begin
    disp_t = frozen ? lap_t : tens;
    disp_u = frozen ? lap_u : units;
  end
`else
  always_comb begin
    disp_t = tens;
    disp_u = units;
  end
`endif

  always_comb begin
    SEG_U = seg7(disp_u);
    SEG_T = seg7({1'b0, disp_t});
  end

endmodule

// File: tb/tb_sec_stage.sv
// Directed bench for sec_stage with DIV=4.
// Covers start, rollover carry, halt, pause/resume, clamped load, reset, lap.
module tb_sec_stage;

  logic       CLK = 1'b0;
  logic       RST_N = 1'b0;
  logic       START = 1'b0;
  logic       PAUSE = 1'b0;
  logic       CLEAR = 1'b0;
  logic       LOAD = 1'b0;
  logic [2:0] LOAD_TENS = '0;
  logic [3:0] LOAD_UNITS = '0;
  logic       MIN_MAX = 1'b0;
  logic       CLK_OUT;
  logic [6:0] SEG_U;
  logic [6:0] SEG_T;
  logic       RUNNING;
  logic       DONE;
`ifdef SEC_STAGE_LAP_EN
  logic       LAP = 1'b0;
`endif

  int n_tests = 0;
  int n_fail  = 0;
  int pulses  = 0;
  int p0;

  localparam logic [6:0] D0 = 7'b1111110;
  localparam logic [6:0] D1 = 7'b0110000;
  localparam logic [6:0] D2 = 7'b1101101;
  localparam logic [6:0] D3 = 7'b1111001;
  localparam logic [6:0] D5 = 7'b1011011;
  localparam logic [6:0] D6 = 7'b1011111;
  localparam logic [6:0] D8 = 7'b1111111;
  localparam logic [6:0] D9 = 7'b1111011;

  sec_stage #(.DIV(4)) dut (
    .CLK(CLK),
    .RST_N(RST_N),
`ifdef SEC_STAGE_LAP_EN
    .LAP(LAP),
`endif
    .START(START),
    .PAUSE(PAUSE),
    .CLEAR(CLEAR),
    .LOAD(LOAD),
    .LOAD_TENS(LOAD_TENS),
    .LOAD_UNITS(LOAD_UNITS),
    .MIN_MAX(MIN_MAX),
    .CLK_OUT(CLK_OUT),
    .SEG_U(SEG_U),
    .SEG_T(SEG_T),
    .RUNNING(RUNNING),
    .DONE(DONE)
  );

  always #5 CLK = ~CLK;

  always @(posedge CLK) if (CLK_OUT) pulses++;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge CLK);
  endtask

  task automatic do_clear();
    CLEAR = 1'b1;
    cyc(1);
    CLEAR = 1'b0;
  endtask

  task automatic do_load(input logic [2:0] t, input logic [3:0] u);
    LOAD = 1'b1;
    LOAD_TENS = t;
    LOAD_UNITS = u;
    cyc(1);
    LOAD = 1'b0;
  endtask

  initial begin
    cyc(2);
    chk("rst_segu", 32'(SEG_U), 32'(D0));
    chk("rst_segt", 32'(SEG_T), 32'(D0));
    chk("rst_run", 32'(RUNNING), 0);
    chk("rst_done", 32'(DONE), 0);
    chk("rst_cout", 32'(CLK_OUT), 0);
    RST_N = 1'b1;
    cyc(1);

    // first tick DIV cycles after the start edge
    START = 1'b1;
    cyc(1);
    START = 1'b0;
    chk("t1_running", 32'(RUNNING), 1);
    cyc(3);
    chk("t1_pre_tick", 32'(SEG_U), 32'(D0));
    cyc(1);
    chk("t1_tick", 32'(SEG_U), 32'(D1));
    do_clear();
    chk("clr_run", 32'(RUNNING), 0);
    chk("clr_segu", 32'(SEG_U), 32'(D0));

    // load 5:8, two ticks -> 00 with one carry
    do_load(3'd5, 4'd8);
    chk("ld_t", 32'(SEG_T), 32'(D5));
    chk("ld_u", 32'(SEG_U), 32'(D8));
    p0 = pulses;
    START = 1'b1;
    cyc(1);
    START = 1'b0;
    cyc(4);
    chk("t2_59", 32'(SEG_U), 32'(D9));
    chk("t2_cout0", 32'(CLK_OUT), 0);
    cyc(4);
    chk("t2_cout1", 32'(CLK_OUT), 1);
    chk("t2_u0", 32'(SEG_U), 32'(D0));
    chk("t2_t0", 32'(SEG_T), 32'(D0));
    cyc(1);
    chk("t2_cout_end", 32'(CLK_OUT), 0);
    cyc(2);
    chk("t2_npulse", 32'(pulses - p0), 1);
    chk("t2_done", 32'(DONE), 0);
    do_clear();

    // halt on rollover with MIN_MAX
    MIN_MAX = 1'b1;
    do_load(3'd5, 4'd9);
    p0 = pulses;
    START = 1'b1;
    cyc(1);
    START = 1'b0;
    cyc(4);
    chk("t3_done", 32'(DONE), 1);
    chk("t3_run", 32'(RUNNING), 0);
    chk("t3_u", 32'(SEG_U), 32'(D9));
    chk("t3_t", 32'(SEG_T), 32'(D5));
    START = 1'b1;
    cyc(2);
    START = 1'b0;
    cyc(4);
    chk("t3_still_done", 32'(DONE), 1);
    chk("t3_still_u", 32'(SEG_U), 32'(D9));
    chk("t3_nopulse", 32'(pulses - p0), 0);
    do_clear();
    MIN_MAX = 1'b0;
    chk("t3_clr_done", 32'(DONE), 0);

    // pause mid-period, resume keeps partial count
    START = 1'b1;
    cyc(1);
    START = 1'b0;
    cyc(4);
    chk("t4_tick1", 32'(SEG_U), 32'(D1));
    cyc(2);
    PAUSE = 1'b1;
    cyc(10);
    PAUSE = 1'b0;
    chk("t4_paused", 32'(RUNNING), 0);
    chk("t4_hold", 32'(SEG_U), 32'(D1));
    START = 1'b1;
    cyc(1);
    START = 1'b0;
    chk("t4_resumed", 32'(RUNNING), 1);
    cyc(1);
    chk("t4_not_yet", 32'(SEG_U), 32'(D1));
    cyc(1);
    chk("t4_tick2", 32'(SEG_U), 32'(D2));

    // clamped load in PAUSE, ignored load in RUN
    PAUSE = 1'b1;
    cyc(1);
    PAUSE = 1'b0;
    do_load(3'd7, 4'd12);
    chk("t5_clamp_t", 32'(SEG_T), 32'(D5));
    chk("t5_clamp_u", 32'(SEG_U), 32'(D9));
    chk("t5_state", 32'(RUNNING), 0);
    START = 1'b1;
    cyc(1);
    START = 1'b0;
    do_load(3'd1, 4'd1);
    chk("t5_run_ign_u", 32'(SEG_U), 32'(D9));
    chk("t5_run_ign_t", 32'(SEG_T), 32'(D5));
    do_clear();

    // CLEAR on the rollover edge beats the carry
    do_load(3'd5, 4'd9);
    p0 = pulses;
    START = 1'b1;
    cyc(1);
    START = 1'b0;
    cyc(3);
    CLEAR = 1'b1;
    cyc(1);
    CLEAR = 1'b0;
    chk("t6_cout", 32'(CLK_OUT), 0);
    chk("t6_u", 32'(SEG_U), 32'(D0));
    cyc(2);
    chk("t6_npulse", 32'(pulses - p0), 0);

    // async reset drops an in-flight carry
    do_load(3'd5, 4'd9);
    START = 1'b1;
    cyc(1);
    START = 1'b0;
    cyc(4);
    chk("t7_cout_hi", 32'(CLK_OUT), 1);
    #1 RST_N = 1'b0;
    #1;
    chk("t7_cout_rst", 32'(CLK_OUT), 0);
    chk("t7_run_rst", 32'(RUNNING), 0);
    chk("t7_seg_rst", 32'(SEG_U), 32'(D0));
    cyc(1);
    RST_N = 1'b1;
    cyc(1);

`ifdef SEC_STAGE_LAP_EN
    do_load(3'd0, 4'd3);
    START = 1'b1;
    cyc(1);
    START = 1'b0;
    LAP = 1'b1;
    cyc(1);
    LAP = 1'b0;
    cyc(11);
    chk("lap_frozen", 32'(SEG_U), 32'(D3));
    LAP = 1'b1;
    cyc(1);
    LAP = 1'b0;
    chk("lap_release", 32'(SEG_U), 32'(D6));
    do_clear();
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: sim did not finish");
    $fatal(1, "timeout");
  end

endmodule
